// File: rtl/draw_pkg.sv
// rtl/draw_pkg.sv - shared types for the triangle dispatcher
package draw_pkg;

   localparam int DEF_COORD_W = 10;

   typedef logic [1:0][DEF_COORD_W-1:0] vertex_t;
   typedef vertex_t [2:0]               triangle_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_LATCH,
      ST_CHECK,
      ST_DISPATCH,
      ST_DRAIN,
      ST_DONE
   } dispatch_state_t;

endpackage

// File: rtl/tri_degenerate_chk.sv
// rtl/tri_degenerate_chk.sv - registered zero-area test for one triangle
module tri_degenerate_chk
   import draw_pkg::*;
#(
   parameter int COORD_W = 10
) (
   input  logic                           Clk,
   input  logic                           Reset,
   input  logic                           load,
   input  logic [2:0][1:0][COORD_W-1:0]   tri_in,
   output logic                           zero
);

   // Differences need one extra bit; the cross product needs twice that plus a sign guard.
   localparam int DW = COORD_W + 1;
   localparam int PW = 2 * COORD_W + 3;

   logic signed [DW-1:0] x0, y0, x1, y1, x2, y2;
   logic signed [DW-1:0] dx1, dy1, dx2, dy2;
   logic signed [PW-1:0] ex1, ey1, ex2, ey2;
   logic signed [PW-1:0] area2;

   // Twice the signed area from zero-extended coordinates; every term fits, so no overflow.
   always_comb begin
      x0    = $signed({1'b0, tri_in[0][0]});
      y0    = $signed({1'b0, tri_in[0][1]});
      x1    = $signed({1'b0, tri_in[1][0]});
      y1    = $signed({1'b0, tri_in[1][1]});
      x2    = $signed({1'b0, tri_in[2][0]});
      y2    = $signed({1'b0, tri_in[2][1]});
      dx1   = x1 - x0;
      dy1   = y1 - y0;
      dx2   = x2 - x0;
      dy2   = y2 - y0;
      ex1   = {{(PW-DW){dx1[DW-1]}}, dx1};
      ey1   = {{(PW-DW){dy1[DW-1]}}, dy1};
      ex2   = {{(PW-DW){dx2[DW-1]}}, dx2};
      ey2   = {{(PW-DW){dy2[DW-1]}}, dy2};
      area2 = (ex1 * ey2) - (ex2 * ey1);
   end

   // Flag is captured alongside the staging register so it is ready one cycle later.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         zero <= 1'b0;
      end else if (load) begin
         zero <= (area2 == '0);
      end
   end

endmodule

// File: rtl/draw_dispatch.sv
// rtl/draw_dispatch.sv - FIFO-draining, culling, round-robin triangle dispatcher
module draw_dispatch
   import draw_pkg::*;
#(
   parameter int COORD_W = 10,
   parameter int NUM_ENG = 2,
   parameter int CNT_W   = 16,
   parameter int CULL_EN = 1
) (
   input  logic                                       Clk,
   input  logic                                       Reset,
   input  logic                                       draw_start,
   input  logic [2:0][1:0][COORD_W-1:0]               triangle_data,
   input  logic                                       fifo_empty,
   output logic                                       fifo_r,
   input  logic [NUM_ENG-1:0]                         eng_done,
   output logic [NUM_ENG-1:0]                         eng_start,
   output logic [NUM_ENG-1:0][2:0][1:0][COORD_W-1:0]  eng_vtx,
   output logic                                       busy,
   output logic                                       draw_done,
   output logic [CNT_W-1:0]                           tri_count,
   output logic [CNT_W-1:0]                           cull_count
);

   localparam int PTR_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

   dispatch_state_t state_q, state_d;

   logic [2:0][1:0][COORD_W-1:0]               stage_q;
   logic [NUM_ENG-1:0][2:0][1:0][COORD_W-1:0]  eng_vtx_q;
   logic [NUM_ENG-1:0]                         busy_q;
   logic [NUM_ENG-1:0]                         avail;
   logic [PTR_W-1:0]                           rr_ptr_q;
   logic [PTR_W-1:0]                           sel;
   logic [PTR_W-1:0]                           cand;
   logic                                       found;
   logic                                       zero_flag;
   logic                                       do_dispatch;
   logic                                       do_cull;
   logic                                       do_clear;
   logic [CNT_W-1:0]                           tri_count_q;
   logic [CNT_W-1:0]                           cull_count_q;

   tri_degenerate_chk #(
      .COORD_W (COORD_W)
   ) u_degen (
      .Clk    (Clk),
      .Reset  (Reset),
      .load   (state_q == ST_LATCH),
      .tri_in (triangle_data),
      .zero   (zero_flag)
   );

   // An engine finishing this cycle is as good as idle for selection and drain.
   assign avail = ~busy_q | eng_done;

   // First available engine at or after rr_ptr, wrapping around the bank.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      cand  = '0;
      for (int i = 0; i < NUM_ENG; i++) begin
         cand = PTR_W'((int'(rr_ptr_q) + i) % NUM_ENG);
         if (!found && avail[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end
   end

   // State register.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and per-cycle strobes.
   always_comb begin
      state_d     = state_q;
      fifo_r      = 1'b0;
      eng_start   = '0;
      draw_done   = 1'b0;
      do_dispatch = 1'b0;
      do_cull     = 1'b0;
      do_clear    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (draw_start) begin
               do_clear = 1'b1;
               state_d  = ST_REQ;
            end
         end
         ST_REQ: begin
            if (fifo_empty) begin
               state_d = ST_DRAIN;
            end else begin
               fifo_r  = 1'b1;
               state_d = ST_LATCH;
            end
         end
         ST_LATCH: begin
            state_d = ST_CHECK;
         end
         ST_CHECK: begin
            if ((CULL_EN != 0) && zero_flag) begin
               do_cull = 1'b1;
               state_d = ST_REQ;
            end else begin
               state_d = ST_DISPATCH;
            end
         end
         ST_DISPATCH: begin
            if (found) begin
               do_dispatch    = 1'b1;
               eng_start[sel] = 1'b1;
               state_d        = ST_REQ;
            end
         end
         ST_DRAIN: begin
            if ((busy_q & ~eng_done) == '0) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            draw_done = 1'b1;
            state_d   = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Staging register holds the popped triangle until it is dispatched or culled.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         stage_q <= '0;
      end else if (state_q == ST_LATCH) begin
         stage_q <= triangle_data;
      end
   end

   // Busy bits: a same-cycle done and restart on one engine leaves it busy.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         busy_q <= '0;
      end else begin
         busy_q <= (busy_q & ~eng_done) | eng_start;
      end
   end

   // Load the chosen engine's vertices and advance the round-robin pointer past it.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         eng_vtx_q <= '0;
         rr_ptr_q  <= '0;
      end else if (do_dispatch) begin
         eng_vtx_q[sel] <= stage_q;
         rr_ptr_q       <= PTR_W'((int'(sel) + 1) % NUM_ENG);
      end
   end

   // Saturating per-frame statistics, cleared only when a frame is accepted.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         tri_count_q  <= '0;
         cull_count_q <= '0;
      end else if (do_clear) begin
         tri_count_q  <= '0;
         cull_count_q <= '0;
      end else begin
         if (do_dispatch && (tri_count_q != '1)) begin
            tri_count_q <= tri_count_q + CNT_W'(1);
         end
         if (do_cull && (cull_count_q != '1)) begin
            cull_count_q <= cull_count_q + CNT_W'(1);
         end
      end
   end

   assign eng_vtx    = eng_vtx_q;
   assign busy       = (state_q != ST_IDLE);
   assign tri_count  = tri_count_q;
   assign cull_count = cull_count_q;

endmodule

// File: tb/tb_draw_dispatch.sv
// tb/tb_draw_dispatch.sv - directed scoreboard bench for draw_dispatch
module tb_draw_dispatch;
   import draw_pkg::*;

   localparam int NE = 2;
   localparam int CW = 10;

   logic Clk = 1'b0;
   logic Reset;
   always #5 Clk = ~Clk;

   logic                          draw_start, fifo_empty, fifo_r, busy, draw_done;
   triangle_t                     triangle_data;
   logic [NE-1:0]                 eng_done, eng_start;
   logic [NE-1:0][2:0][1:0][CW-1:0] eng_vtx;
   logic [15:0]                   tri_count, cull_count;

   logic                          ds1, fe1, fr1, busy1, done1_o;
   triangle_t                     td1;
   logic [NE-1:0]                 ed1, es1;
   logic [NE-1:0][2:0][1:0][CW-1:0] vtx1;
   logic [15:0]                   tc1, cc1;

   draw_dispatch #(.COORD_W(CW), .NUM_ENG(NE), .CNT_W(16), .CULL_EN(1)) dut (
      .Clk(Clk), .Reset(Reset), .draw_start(draw_start), .triangle_data(triangle_data),
      .fifo_empty(fifo_empty), .fifo_r(fifo_r), .eng_done(eng_done), .eng_start(eng_start),
      .eng_vtx(eng_vtx), .busy(busy), .draw_done(draw_done), .tri_count(tri_count),
      .cull_count(cull_count));

   draw_dispatch #(.COORD_W(CW), .NUM_ENG(NE), .CNT_W(16), .CULL_EN(0)) dut_nocull (
      .Clk(Clk), .Reset(Reset), .draw_start(ds1), .triangle_data(td1),
      .fifo_empty(fe1), .fifo_r(fr1), .eng_done(ed1), .eng_start(es1),
      .eng_vtx(vtx1), .busy(busy1), .draw_done(done1_o), .tri_count(tc1),
      .cull_count(cc1));

   typedef struct { int eng; triangle_t t; } exp_t;
   exp_t      sb[$];

   triangle_t mem [0:31];
   int        wr, rd;
   int        checks, failures;
   int        cyc, t0, first_fr, first_es, done_cyc, last_done, n_es, fc;
   int        start_cyc [NE];
   int        cnt [NE];
   int        lat [NE];
   logic      pend [NE];
   triangle_t pvtx [NE];
   logic [NE-1:0] force_done, es1_bits, es1_prev;
   logic      done1_seen;
   triangle_t A, B, C, D, T1, T2, T3, M, X, Y, Z, W;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic triangle_t mk(input int x0, input int y0, input int x1,
                                    input int y1, input int x2, input int y2);
      triangle_t t;
      t[0][0] = CW'(x0); t[0][1] = CW'(y0);
      t[1][0] = CW'(x1); t[1][1] = CW'(y1);
      t[2][0] = CW'(x2); t[2][1] = CW'(y2);
      return t;
   endfunction

   task automatic push(input triangle_t t);
      mem[wr] = t;
      wr++;
      fifo_empty = (rd == wr);
   endtask

   task automatic expect_start(input int e, input triangle_t t);
      exp_t x;
      x.eng = e;
      x.t   = t;
      sb.push_back(x);
   endtask

   // Observe the current cycle, then advance one clock and drive the next cycle's inputs.
   task automatic tick();
      logic          fr, fr1s;
      logic [NE-1:0] es;
      exp_t          x;
      fr   = fifo_r;
      fr1s = fr1;
      es   = eng_start;
      for (int e = 0; e < NE; e++) begin
         if (pend[e]) begin
            chk("eng_vtx_loaded", 64'(eng_vtx[e]), 64'(pvtx[e]));
            pend[e] = 1'b0;
         end
      end
      for (int e = 0; e < NE; e++) begin
         if (es[e]) begin
            start_cyc[e] = cyc;
            if (sb.size() == 0) begin
               chk("unexpected_eng_start", 64'(e), 64'hFFFF);
            end else begin
               x = sb.pop_front();
               chk("eng_start_engine", 64'(e), 64'(x.eng));
               pend[e] = 1'b1;
               pvtx[e] = x.t;
            end
            cnt[e] = lat[e];
         end
      end
      n_es += $countones(es);
      if (fr && first_fr < 0) first_fr = cyc;
      if (es != '0 && first_es < 0) first_es = cyc;
      if (draw_done) done_cyc = cyc;
      if (eng_done != '0) last_done = cyc;
      es1_bits = es1_bits | es1;
      es1_prev = es1;
      if (done1_o) done1_seen = 1'b1;
      @(posedge Clk);
      #1;
      cyc++;
      if (fr) begin
         triangle_data = mem[rd];
         rd++;
         fifo_empty = (rd == wr);
      end
      if (fr1s) fe1 = 1'b1;
      ed1 = es1_prev;
      eng_done = '0;
      for (int e = 0; e < NE; e++) begin
         if (cnt[e] > 0) begin
            cnt[e]--;
            if (cnt[e] == 0) eng_done[e] = 1'b1;
         end
      end
      eng_done   = eng_done | force_done;
      force_done = '0;
      #1;
   endtask

   task automatic start_frame();
      first_fr   = -1;
      first_es   = -1;
      done_cyc   = -1;
      draw_start = 1'b1;
      t0         = cyc;
      tick();
      draw_start = 1'b0;
      ds1        = 1'b0;
   endtask

   task automatic run_until_done(input int budget);
      for (int i = 0; i < budget && done_cyc < 0; i++) tick();
      chk("draw_done_timeout", 64'(done_cyc >= 0), 64'd1);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_fifo_r"},     64'(fifo_r), 64'd0);
      chk({tag, "_eng_start"},  64'(eng_start), 64'd0);
      chk({tag, "_busy"},       64'(busy), 64'd0);
      chk({tag, "_draw_done"},  64'(draw_done), 64'd0);
      chk({tag, "_tri_count"},  64'(tri_count), 64'd0);
      chk({tag, "_cull_count"}, 64'(cull_count), 64'd0);
      chk({tag, "_eng_vtx0"},   64'(eng_vtx[0]), 64'd0);
      chk({tag, "_eng_vtx1"},   64'(eng_vtx[1]), 64'd0);
   endtask

   initial begin
      int n0;
      checks = 0; failures = 0; cyc = 0; wr = 0; rd = 0; n_es = 0; last_done = -1;
      Reset = 1'b0; draw_start = 1'b0; fifo_empty = 1'b1; triangle_data = '0;
      eng_done = '0; force_done = '0;
      ds1 = 1'b0; fe1 = 1'b0; td1 = '0; ed1 = '0; es1_bits = '0; es1_prev = '0; done1_seen = 1'b0;
      for (int e = 0; e < NE; e++) begin
         cnt[e] = 0; lat[e] = 2; pend[e] = 1'b0; pvtx[e] = '0; start_cyc[e] = -1;
      end
      first_fr = -1; first_es = -1; done_cyc = -1;

      A  = mk(0, 0, 10, 0, 0, 10);
      B  = mk(5, 5, 100, 20, 30, 200);
      C  = mk(1023, 1023, 0, 1023, 1023, 0);
      D  = mk(0, 0, 5, 5, 10, 10);
      T1 = mk(1, 2, 300, 4, 5, 600);
      T2 = mk(7, 8, 9, 400, 500, 11);
      T3 = mk(20, 30, 40, 90, 700, 60);
      M  = mk(1023, 0, 0, 1023, 1023, 1023);
      X  = mk(3, 3, 50, 3, 3, 50);
      Y  = mk(60, 10, 10, 60, 90, 90);
      Z  = mk(100, 100, 200, 100, 100, 300);
      W  = mk(11, 22, 333, 44, 55, 666);

      // Reset state
      repeat (3) tick();
      check_all_zero("reset");
      Reset = 1'b1;
      tick();

      // Empty FIFO frame
      n0 = n_es;
      start_frame();
      run_until_done(50);
      chk("empty_no_fifo_r", 64'(first_fr < 0), 64'd1);
      chk("empty_no_start", 64'(n_es - n0), 64'd0);
      chk("empty_done_latency", 64'(done_cyc - t0), 64'd3);
      chk("empty_tri_count", 64'(tri_count), 64'd0);

      // Three triangles, round robin 0,1,0
      push(A); push(B); push(C);
      expect_start(0, A); expect_start(1, B); expect_start(0, C);
      start_frame();
      run_until_done(200);
      chk("rr_first_fifo_r", 64'(first_fr - t0), 64'd1);
      chk("rr_first_start", 64'(first_es - t0), 64'd4);
      chk("rr_steady_state", 64'(start_cyc[1] - first_es), 64'd4);
      chk("rr_tri_count", 64'(tri_count), 64'd3);
      chk("rr_cull_count", 64'(cull_count), 64'd0);
      chk("rr_done_after_last_eng_done", 64'(done_cyc > last_done), 64'd1);
      chk("rr_scoreboard_empty", 64'(sb.size()), 64'd0);
      tick();

      // Degenerate triangle: culled with culling on, dispatched with it off
      n0 = n_es;
      push(D);
      td1 = D; fe1 = 1'b0; ds1 = 1'b1;
      start_frame();
      run_until_done(100);
      for (int i = 0; i < 30 && !done1_seen; i++) tick();
      chk("cull_cull_count", 64'(cull_count), 64'd1);
      chk("cull_tri_count", 64'(tri_count), 64'd0);
      chk("cull_no_start", 64'(n_es - n0), 64'd0);
      chk("nocull_tri_count", 64'(tc1), 64'd1);
      chk("nocull_cull_count", 64'(cc1), 64'd0);
      chk("nocull_engine", 64'(es1_bits), 64'd1);
      chk("nocull_vtx", 64'(vtx1[0]), 64'(D));
      chk("nocull_done", 64'(done1_seen), 64'd1);
      tick();

      // Both engines held busy, third triangle waits in DISPATCH
      lat[0] = 0; lat[1] = 0;
      n0 = n_es;
      push(T1); push(T2); push(T3);
      expect_start(1, T1); expect_start(0, T2); expect_start(1, T3);
      start_frame();
      repeat (30) tick();
      chk("hold_busy", 64'(busy), 64'd1);
      chk("hold_starts", 64'(n_es - n0), 64'd2);
      chk("hold_pending", 64'(sb.size()), 64'd1);
      force_done = 2'b10;
      tick();
      fc = cyc;
      tick();
      chk("hold_freed_same_cycle", 64'(start_cyc[1]), 64'(fc));
      chk("hold_vtx0_unchanged", 64'(eng_vtx[0]), 64'(T2));
      chk("hold_vtx1_third", 64'(eng_vtx[1]), 64'(T3));
      force_done = 2'b11;
      run_until_done(100);
      chk("hold_tri_count", 64'(tri_count), 64'd3);
      chk("hold_scoreboard_empty", 64'(sb.size()), 64'd0);
      tick();

      // Maximum coordinates
      lat[0] = 2; lat[1] = 2;
      push(M);
      expect_start(0, M);
      start_frame();
      run_until_done(100);
      chk("max_tri_count", 64'(tri_count), 64'd1);
      chk("max_cull_count", 64'(cull_count), 64'd0);
      chk("max_scoreboard_empty", 64'(sb.size()), 64'd0);
      tick();

      // Reset while holding in DISPATCH
      lat[0] = 0; lat[1] = 0;
      push(X); push(Y); push(Z);
      expect_start(1, X); expect_start(0, Y);
      start_frame();
      repeat (16) tick();
      chk("midreset_busy_before", 64'(busy), 64'd1);
      chk("midreset_scoreboard", 64'(sb.size()), 64'd0);
      #2;
      Reset = 1'b0;
      #1;
      check_all_zero("midreset");
      for (int e = 0; e < NE; e++) begin
         cnt[e] = 0; lat[e] = 2; pend[e] = 1'b0;
      end
      rd = wr; fifo_empty = 1'b1;
      tick();
      tick();
      Reset = 1'b1;
      tick();
      push(W);
      expect_start(0, W);
      start_frame();
      run_until_done(100);
      chk("restart_first_start", 64'(first_es - t0), 64'd4);
      chk("restart_tri_count", 64'(tri_count), 64'd1);
      chk("restart_scoreboard_empty", 64'(sb.size()), 64'd0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/draw_dispatch.md
Name: draw_dispatch

Overview:
Multi-engine triangle dispatcher. It pops screen-space triangles from the vertex FIFO and culls zero-area triangles. Surviving triangles go round-robin to NUM_ENG triangle-raster engines, so several can rasterise concurrently. It sits between the vertex-transform FIFO and the rasteriser bank and signals frame completion only when the FIFO is empty and every engine has finished.

Parameters:
COORD_W, 10, bits per vertex coordinate (unsigned screen x/y)
NUM_ENG, 2, number of raster engines (1..8)
CNT_W, 16, width of statistics counters
CULL_EN, 1, 1 = drop zero-area triangles; 0 = dispatch all

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-low reset
draw_start  in  1  pulse: begin draining FIFO for a frame
triangle_data  in  [2:0][1:0][COORD_W-1:0]  FIFO head; [v][0]=x, [v][1]=y; valid the cycle after fifo_r
fifo_empty  in  1  FIFO has no entries
fifo_r  out  1  one-cycle FIFO pop
eng_done  in  NUM_ENG  per-engine one-cycle completion pulse
eng_start  out  NUM_ENG  per-engine one-cycle start pulse
eng_vtx  out  [NUM_ENG-1:0][2:0][1:0][COORD_W-1:0]  per-engine registered vertices, stable while that engine is busy
busy  out  1  high in any state except IDLE
draw_done  out  1  one-cycle pulse at frame completion
tri_count  out  CNT_W  triangles dispatched this frame, saturating
cull_count  out  CNT_W  triangles culled this frame, saturating

Behaviour:
- Reset (Reset=0, async): state IDLE; all outputs 0, including eng_vtx, engine busy bits, rr_ptr and counters.
- FSM states: IDLE, REQ, LATCH, CHECK, DISPATCH, DRAIN, DONE.
- IDLE: if draw_start=1, clear tri_count and cull_count, then go to REQ. draw_start is ignored in every other state.
- REQ: if fifo_empty=1, go to DRAIN. Otherwise assert fifo_r for this cycle only and go to LATCH.
- LATCH: capture triangle_data into the staging register; go to CHECK.
- CHECK: the registered degenerate flag is valid here.
  - If CULL_EN=1 and area2==0: increment cull_count and go to REQ.
  - Otherwise go to DISPATCH.
- Area arithmetic: operands zero-extended to COORD_W+1 signed. area2 = (x1-x0)*(y2-y0) - (x2-x0)*(y1-y0), computed at 2*COORD_W+3 bits. No overflow is permitted.
- DISPATCH: search for the first idle engine starting at rr_ptr, wrapping mod NUM_ENG.
  - If found: load its eng_vtx, pulse its eng_start for 1 cycle, set its busy bit, set rr_ptr = index+1 mod NUM_ENG, increment tri_count, go to REQ.
  - If none is idle: hold in DISPATCH with no pulse.
- DRAIN: wait until all busy bits are 0, then go to DONE. A busy engine whose eng_done arrives this same cycle counts as idle.
- DONE: draw_done=1 for one cycle; go to IDLE.
- Engine busy bits: set on eng_start, cleared on eng_done. eng_done for an idle engine is ignored. An engine freed by eng_done is selectable in the same DISPATCH cycle.
- Minimum latency: draw_start at cycle 0 gives fifo_r at cycle 1 and the first eng_start at cycle 4. Steady state is 4 cycles per triangle when engines are free.
- Empty FIFO at start: draw_start, then REQ, DRAIN, DONE; draw_done arrives 3 cycles after draw_start with counters at 0.
- Counters saturate at 2^CNT_W-1 and hold through IDLE until the next accepted draw_start.
- Reset mid-frame: abandons the in-flight triangle and clears busy bits. The engines are reset by the same Reset.

Decomposition:
- Package draw_pkg:
  - typedef vertex_t = [1:0][COORD_W-1:0]
  - typedef triangle_t = [2:0] vertex_t
  - state enum dispatch_state_t
- Sub-module tri_degenerate_chk: registered area2 computation producing a 1-bit zero flag, one cycle latency.
- Round-robin idle-engine select stays inline.

Test Plan:
- Empty FIFO (fifo_empty=1), draw_start -> no fifo_r, no eng_start; draw_done at cycle 3; tri_count=0.
- 3 triangles, NUM_ENG=2, engines finish 2 cycles after start -> eng_start order engine 0, 1, 0; tri_count=3; draw_done only after the last eng_done.
- Triangle (0,0),(5,5),(10,10), CULL_EN=1 -> no eng_start; cull_count=1. Same triangle with CULL_EN=0 -> dispatched, tri_count=1.
- Both engines held busy, 3rd triangle pending -> FSM holds in DISPATCH. eng_done[1] pulses -> eng_start[1] the same cycle, eng_vtx[1] = the third triangle, eng_vtx[0] unchanged.
- Max coordinates (1023,0),(0,1023),(1023,1023) -> area2 nonzero, no overflow, dispatched.
- Reset low while in DISPATCH with engine 0 busy -> all outputs 0 immediately. After release, draw_start restarts cleanly at engine 0.
